// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader: FSM states, default
// end-of-program marker and the writable capacity of the target memory.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } ldr_state_e;

  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_DATA_W-1:0] DEF_END_WORD = '1;

  // Number of words that fit between the base address and the top of memory.
  function automatic int ldr_capacity(input int addr_w, input int base);
    return (1 << addr_w) - base;
  endfunction

endpackage

// File: rtl/ldr_fifo.sv
// First-word-fall-through FIFO with flush; the head word is visible on rdata
// whenever empty is low.
module ldr_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push against a full FIFO is
  // only honoured alongside a pop.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/prog_loader.sv
// Streams instruction words from a valid/ready source into instruction memory
// at consecutive addresses from BASE_ADDR, buffered through a small FIFO.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 8,
  parameter int                BASE_ADDR  = 0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                END_EN     = 1,
  parameter logic [DATA_W-1:0] END_WORD   = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W:0]   CAP      = (ADDR_W+1)'(ldr_capacity(ADDR_W, BASE_ADDR));
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  ldr_state_e        state;
  ldr_state_e        state_nxt;
  logic [ADDR_W:0]   acc_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_flush;
  logic              is_end;
  logic              xfer;
  logic              at_cap;
  logic              session_start;
  logic              push;
  logic              pop;

  assign is_end        = (END_EN != 0) && (in_data == END_WORD);
  assign xfer          = in_valid && in_ready;
  assign at_cap        = (acc_cnt == CAP);
  assign session_start = start && (state == IDLE || state == DONE || state == ERR);
  assign push          = xfer && !is_end && !at_cap;
  assign pop           = mem_we && mem_ready;
  // Overflow discards everything still buffered so nothing more reaches memory.
  assign fifo_flush    = session_start || (xfer && !is_end && at_cap);

  ldr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .flush (fifo_flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LOAD;
      LOAD: begin
        // The end marker outranks in_last: it is swallowed, never written.
        if (xfer) begin
          if (is_end)       state_nxt = DRAIN;
          else if (at_cap)  state_nxt = ERR;
          else if (in_last) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD) && !fifo_full;
    mem_we    = (state == LOAD || state == DRAIN) && !fifo_empty;
    mem_wdata = fifo_empty ? '0 : fifo_head;
    busy      = (state == LOAD || state == DRAIN);
    done      = (state == DONE);
    err_ovf   = (state == ERR);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_addr <= BASE;
      word_cnt <= '0;
      acc_cnt  <= '0;
    end else if (session_start) begin
      mem_addr <= BASE;
      word_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      if (pop) begin
        word_cnt <= word_cnt + CNT_ONE;
        // Hold at the top address after the final write instead of wrapping.
        if (mem_addr != ADDR_MAX) mem_addr <= mem_addr + ADDR_ONE;
      end
      if (push) acc_cnt <= acc_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: three instances (default, base 0x10, 3-bit address at
// base 6) checked every cycle against a queue-level model plus literal results.
module tb_prog_loader;

  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3, M_ERR = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  start_s;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        mem_ready;

  logic [2:0]  rdy, we, bsy, dn, er;
  logic [7:0]  a0, a1;
  logic [2:0]  a2;
  logic [15:0] d0, d1, d2;
  logic [8:0]  c0, c1;
  logic [3:0]  c2;

  int n_chk = 0;
  int n_fail = 0;

  int base_i [3] = '{0, 16, 6};
  int amax   [3] = '{255, 255, 7};
  int cap    [3] = '{256, 240, 2};

  int          mst  [3] = '{0, 0, 0};
  int          qh   [3] = '{0, 0, 0};
  int          qt   [3] = '{0, 0, 0};
  int          nwr  [3] = '{0, 0, 0};
  int          nacc [3] = '{0, 0, 0};
  logic [15:0] mq   [3][64];

  logic [15:0] img [3][256];
  int          nw_seen [3] = '{0, 0, 0};
  bit          we_seen [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  prog_loader u0 (
    .clk(clk), .rst_b(rst_b), .start(start_s[0]), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(a0), .mem_wdata(d0),
    .mem_ready(mem_ready), .busy(bsy[0]), .done(dn[0]), .err_ovf(er[0]), .word_cnt(c0)
  );

  prog_loader #(.BASE_ADDR(16)) u1 (
    .clk(clk), .rst_b(rst_b), .start(start_s[1]), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(a1), .mem_wdata(d1),
    .mem_ready(mem_ready), .busy(bsy[1]), .done(dn[1]), .err_ovf(er[1]), .word_cnt(c1)
  );

  prog_loader #(.ADDR_W(3), .BASE_ADDR(6)) u2 (
    .clk(clk), .rst_b(rst_b), .start(start_s[2]), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[2]), .mem_we(we[2]), .mem_addr(a2), .mem_wdata(d2),
    .mem_ready(mem_ready), .busy(bsy[2]), .done(dn[2]), .err_ovf(er[2]), .word_cnt(c2)
  );

  function automatic int get_addr(int i);
    if (i == 0) return int'(a0);
    if (i == 1) return int'(a1);
    return int'(a2);
  endfunction

  function automatic int get_data(int i);
    if (i == 0) return int'(d0);
    if (i == 1) return int'(d1);
    return int'(d2);
  endfunction

  function automatic int get_cnt(int i);
    if (i == 0) return int'(c0);
    if (i == 1) return int'(c1);
    return int'(c2);
  endfunction

  task automatic check(string nm, int i, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got 0x%0h, expected 0x%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: a session is a queue of accepted words; writes drain the queue in
  // order to base+n, capacity-bounded, with the end marker never queued.
  task automatic model_step(int i);
    int  occ;
    bit  rdy_e, we_e;
    occ   = qt[i] - qh[i];
    rdy_e = (mst[i] == M_LOAD) && (occ < 4);
    we_e  = (mst[i] == M_LOAD || mst[i] == M_DRAIN) && (occ > 0);
    if (start_s[i] && (mst[i] == M_IDLE || mst[i] == M_DONE || mst[i] == M_ERR)) begin
      mst[i] = M_LOAD; qh[i] = 0; qt[i] = 0; nwr[i] = 0; nacc[i] = 0;
      return;
    end
    if (we_e && mem_ready) begin
      qh[i]++;
      nwr[i]++;
    end
    if (mst[i] == M_DRAIN && occ == 0) begin
      mst[i] = M_DONE;
    end else if (mst[i] == M_LOAD && in_valid && rdy_e) begin
      if (in_data == 16'hFFFF) begin
        mst[i] = M_DRAIN;
      end else if (nacc[i] == cap[i]) begin
        mst[i] = M_ERR;
        qh[i]  = qt[i];
      end else begin
        mq[i][qt[i] % 64] = in_data;
        qt[i]++;
        nacc[i]++;
        if (in_last) mst[i] = M_DRAIN;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_b);
      for (int i = 0; i < 3; i++) begin
        if (!rst_b) begin
          mst[i] = M_IDLE; qh[i] = 0; qt[i] = 0; nwr[i] = 0; nacc[i] = 0;
        end else begin
          model_step(i);
        end
      end
    end
  end

  initial begin
    int occ, ea, ed;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        occ = qt[i] - qh[i];
        ea  = base_i[i] + nwr[i];
        if (ea > amax[i]) ea = amax[i];
        ed  = (occ > 0) ? int'(mq[i][qh[i] % 64]) : 0;
        check("in_ready", i, int'(rdy[i]), int'(mst[i] == M_LOAD && occ < 4));
        check("mem_we", i, int'(we[i]), int'((mst[i] == M_LOAD || mst[i] == M_DRAIN) && occ > 0));
        check("mem_addr", i, get_addr(i), ea);
        check("mem_wdata", i, get_data(i), ed);
        check("busy", i, int'(bsy[i]), int'(mst[i] == M_LOAD || mst[i] == M_DRAIN));
        check("done", i, int'(dn[i]), int'(mst[i] == M_DONE));
        check("err_ovf", i, int'(er[i]), int'(mst[i] == M_ERR));
        check("word_cnt", i, get_cnt(i), nwr[i]);
        if (we[i]) we_seen[i] = 1'b1;
        if (we[i] && mem_ready) begin
          img[i][get_addr(i)] = 16'(get_data(i));
          nw_seen[i]++;
        end
      end
    end
  end

  task automatic pulse_start(int i);
    start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
  endtask

  task automatic send(int i, logic [15:0] d, logic l);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = rdy[i];
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("send_accepted", i, int'(ok), 1);
  endtask

  task automatic wait_end(int i);
    int t;
    t = 0;
    while (!(dn[i] || er[i]) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("end_reached", i, int'(t < 100), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w [6];
    int k, t;
    bit took;
    w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 256; j++) img[i][j] = 16'hDEAD;
    rst_b = 1'b0; start_s = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    check("rst_addr", 1, int'(a1), 16);
    check("rst_cnt", 0, int'(c0), 0);
    check("rst_ready", 0, int'(rdy[0]), 0);

    // Marker-terminated load at base 0
    pulse_start(0);
    send(0, 16'h1111, 1'b0);
    send(0, 16'h2222, 1'b0);
    send(0, 16'h3333, 1'b0);
    send(0, 16'hFFFF, 1'b0);
    wait_end(0);
    check("t1_m0", 0, int'(img[0][0]), 16'h1111);
    check("t1_m1", 0, int'(img[0][1]), 16'h2222);
    check("t1_m2", 0, int'(img[0][2]), 16'h3333);
    check("t1_m3_unwritten", 0, int'(img[0][3]), 16'hDEAD);
    check("t1_cnt", 0, int'(c0), 3);
    check("t1_done", 0, int'(dn[0]), 1);

    // in_last-terminated load at base 0x10
    pulse_start(1);
    send(1, 16'hAAAA, 1'b0);
    send(1, 16'hBBBB, 1'b1);
    wait_end(1);
    check("t2_m10", 1, int'(img[1][16]), 16'hAAAA);
    check("t2_m11", 1, int'(img[1][17]), 16'hBBBB);
    check("t2_cnt", 1, int'(c1), 2);
    check("t2_done", 1, int'(dn[1]), 1);

    // Memory stall: only FIFO_DEPTH words get in
    mem_ready = 1'b0;
    pulse_start(0);
    k = 0;
    in_valid = 1'b1; in_data = w[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = rdy[0];
      @(posedge clk); #1;
      if (took) begin
        k++;
        if (k < 6) in_data = w[k];
      end
    end
    in_valid = 1'b0;
    check("t3_accepted", 0, k, 4);
    check("t3_ready_low", 0, int'(rdy[0]), 0);
    check("t3_addr_held", 0, int'(a0), 0);
    check("t3_data_held", 0, int'(d0), 16'h0101);
    mem_ready = 1'b1;
    for (int j = k; j < 6; j++) send(0, w[j], 1'b0);
    send(0, 16'hFFFF, 1'b0);
    wait_end(0);
    for (int j = 0; j < 6; j++) check("t3_mem", j, int'(img[0][j]), int'(w[j]));
    check("t3_cnt", 0, int'(c0), 6);

    // Overflow at the top of a 3-bit address space
    pulse_start(2);
    send(2, 16'h0A0A, 1'b0);
    send(2, 16'h0B0B, 1'b0);
    send(2, 16'h0C0C, 1'b0);
    wait_end(2);
    check("t4_err", 2, int'(er[2]), 1);
    check("t4_m6", 2, int'(img[2][6]), 16'h0A0A);
    check("t4_m7", 2, int'(img[2][7]), 16'h0B0B);
    check("t4_m0_untouched", 2, int'(img[2][0]), 16'hDEAD);
    check("t4_writes", 2, nw_seen[2], 2);
    check("t4_cnt", 2, int'(c2), 2);

    // Asynchronous reset in the middle of a session
    pulse_start(0);
    send(0, 16'h5151, 1'b0);
    send(0, 16'h5252, 1'b0);
    t = 0;
    while (c0 != 9'd2 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("t5_two_writes", 0, int'(c0), 2);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    check("t5_rst_ready", 0, int'(rdy[0]), 0);
    check("t5_rst_we", 0, int'(we[0]), 0);
    check("t5_rst_addr", 0, int'(a0), 0);
    check("t5_rst_wdata", 0, int'(d0), 0);
    check("t5_rst_busy", 0, int'(bsy[0]), 0);
    check("t5_rst_done", 0, int'(dn[0]), 0);
    check("t5_rst_err", 2, int'(er[2]), 0);
    check("t5_rst_cnt", 0, int'(c0), 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    pulse_start(0);
    send(0, 16'h7777, 1'b0);
    send(0, 16'hFFFF, 1'b0);
    wait_end(0);
    check("t5_reload_m0", 0, int'(img[0][0]), 16'h7777);
    check("t5_reload_cnt", 0, int'(c0), 1);

    // Empty session; marker with in_last is still swallowed
    pulse_start(0);
    we_seen[0] = 1'b0;
    send(0, 16'hFFFF, 1'b1);
    wait_end(0);
    check("t6_done", 0, int'(dn[0]), 1);
    check("t6_cnt", 0, int'(c0), 0);
    check("t6_no_we", 0, int'(we_seen[0]), 0);

    // start during LOAD must not restart the session
    pulse_start(0);
    send(0, 16'h4242, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(0);
    send(0, 16'h4343, 1'b1);
    wait_end(0);
    check("t7_cnt", 0, int'(c0), 2);
    check("t7_m1", 0, int'(img[0][1]), 16'h4343);
    check("t7_done", 0, int'(dn[0]), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Synthesizable successor to the file-driven machine-code source. It accepts a stream of instruction words over a valid/ready handshake and buffers them in a small FIFO. It writes them into instruction memory at consecutive addresses from a configurable base. It signals completion on an end-of-program marker or an explicit last flag. It sits between the program source (testbench feeder, UART or debug port) and the processor's instruction memory write port.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 8, instruction memory address width
BASE_ADDR, 0, first write address; must be < 2**ADDR_W
FIFO_DEPTH, 4, internal buffer depth in words; power of two, >= 2
END_EN, 1, 1 = treat END_WORD as the end-of-program marker
END_WORD, {DATA_W{1'b1}}, marker value; when END_EN=1 it is consumed but never written

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load session from IDLE, DONE or ERR
in_valid  in  1  source word valid
in_data  in  DATA_W  source word
in_last  in  1  qualifies in_data as the final word; that word is written
in_ready  out  1  loader accepts the word this cycle
mem_we  out  1  memory write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  high in LOAD or DRAIN
done  out  1  high in DONE
err_ovf  out  1  high in ERR
word_cnt  out  ADDR_W+1  number of words written in the current or last session

Behaviour:
- Reset (asynchronous, rst_b low): state IDLE, FIFO flushed, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err_ovf=0, word_cnt=0. Reset mid-session aborts the session; the memory keeps any words already written.
- FSM states: IDLE, LOAD, DRAIN, DONE, ERR.
  - IDLE/DONE/ERR + start -> LOAD. On entry: mem_addr=BASE_ADDR, word_cnt=0, accepted-count=0, FIFO flushed.
  - In LOAD and DRAIN, start is ignored.
- Input handshake:
  - in_ready = (state==LOAD) && !fifo_full. It is combinational from registered state only and never depends on in_valid.
  - A transfer occurs when in_valid && in_ready.
  - An END_WORD transfer (END_EN=1) is not pushed and moves LOAD -> DRAIN.
  - An in_last transfer pushes the word and moves LOAD -> DRAIN.
  - If a word equals END_WORD and has in_last set, the END_WORD rule wins: the word is not pushed.
- Capacity: CAP = 2**ADDR_W - BASE_ADDR. A push attempt when accepted-count == CAP is an overflow:
  - the word is dropped;
  - the FSM moves to ERR;
  - the FIFO is flushed;
  - no further writes occur.
  - mem_addr never wraps.
- Memory side:
  - mem_we = (state in LOAD or DRAIN) && !fifo_empty.
  - mem_wdata = FIFO head (first-word-fall-through).
  - A write completes when mem_we && mem_ready. On completion: pop, mem_addr+1, word_cnt+1.
  - mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
- FIFO:
  - A push and a pop in the same cycle are both honoured, with the count unchanged. This is legal when the FIFO is full: pop first, so in_ready stays 0 when full, with no bypass.
- Latency: a word accepted in cycle N appears on mem_we/mem_wdata in cycle N+1 at the earliest. Steady-state throughput is one word per cycle with mem_ready held high.
- DRAIN -> DONE when the FIFO is empty after the last write completes. DONE and ERR hold their flags until start or reset.
- An empty session (END_WORD as the first word) goes LOAD -> DRAIN -> DONE with word_cnt=0.

Decomposition:
- Package loader_pkg:
  - state enum {IDLE, LOAD, DRAIN, DONE, ERR};
  - default END_WORD constant;
  - capacity helper function.
- Sub-module ldr_fifo (parameters DATA_W, DEPTH):
  - synchronous FWFT FIFO with push, pop, full, empty, flush;
  - asynchronous active-low reset, using the same port names clk and rst_b.
- The top level holds the FSM, counters and address generation.

Test Plan:
- start, then words 0x1111, 0x2222, 0x3333, 0xFFFF with mem_ready=1 -> writes to addresses 0, 1, 2; 0xFFFF not written; done=1; word_cnt=3.
- BASE_ADDR=0x10, 2 words, second word has in_last=1 -> writes at 0x10 and 0x11; done=1; word_cnt=2.
- mem_ready=0 for 10 cycles while 6 words are offered -> in_ready drops after 4 accepted words (FIFO_DEPTH=4); mem_addr/mem_wdata stable; after release all 6 words are written in order, with no loss or duplicates.
- ADDR_W=3, BASE_ADDR=6, 3 words without a marker -> addresses 6 and 7 written; third word dropped; err_ovf=1; no write to address 0.
- rst_b asserted mid-LOAD after 2 writes -> all outputs at reset values immediately; a subsequent start reloads from BASE_ADDR with word_cnt=0.
- END_WORD as the first word -> done=1, word_cnt=0, mem_we never asserted; a start pulse during LOAD is ignored.
